// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, mid-bit sampling.
// Ports: clk, resetn (sync, active-low), rx_i (async serial line, idles high),
//        e_o (byte strobe), d_o (last good byte), frame_err_o (bad stop
//        bit strobe), busy_o (frame in progress).
module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rx_i,
    output logic       e_o,
    output logic [7:0] d_o,
    output logic       frame_err_o,
    output logic       busy_o
);

    localparam int TW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [TW-1:0] FULL = TW'(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2);
    localparam logic [TW-1:0] ONE  = TW'(1);
    localparam logic [TW-1:0] ZERO = '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    logic          rx_meta_q;
    logic          rx_s_q;
    state_t        state_q;
    logic [TW-1:0] timer_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic [7:0]    d_q;
    logic          e_q;
    logic          ferr_q;
    logic          tick;

    // Sample event: the cycle the down-counter reaches 1.
    assign tick = (timer_q == ONE);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= S_IDLE;
            timer_q   <= ZERO;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            d_q       <= 8'h00;
            e_q       <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
            e_q       <= 1'b0;
            ferr_q    <= 1'b0;

            // Free-running reload; state-specific loads below override it.
            if (tick)
                timer_q <= FULL;
            else if (timer_q != ZERO)
                timer_q <= timer_q - ONE;

            case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        state_q <= S_START;
                        timer_q <= HALF;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (!rx_s_q) begin
                            state_q   <= S_DATA;
                            bit_idx_q <= 3'd0;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        shift_q[bit_idx_q] <= rx_s_q;
                        bit_idx_q          <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7)
                            state_q <= S_STOP;
                    end
                end
                S_STOP: begin
                    // Leave at mid-stop so a following start edge is not missed.
                    if (tick) begin
                        if (rx_s_q) begin
                            e_q     <= 1'b1;
                            d_q     <= shift_q;
                            state_q <= S_IDLE;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    if (rx_s_q)
                        state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign e_o         = e_q;
    assign d_o         = d_q;
    assign frame_err_o = ferr_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx at CLKS_PER_BIT=16.
// A behavioural serial driver plays the far-end transmitter.
module tb_uart_rx;

    localparam int CPB   = 16;
    localparam int CLK_NS = 10;
    localparam int BIT_NS = CPB * CLK_NS;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       rx_i = 1'b1;
    logic       e_o;
    logic [7:0] d_o;
    logic       frame_err_o;
    logic       busy_o;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    logic [7:0] got[$];
    int         got_t[$];
    int         ferr_cnt = 0;
    int         both_cnt = 0;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk),
        .resetn(resetn),
        .rx_i(rx_i),
        .e_o(e_o),
        .d_o(d_o),
        .frame_err_o(frame_err_o),
        .busy_o(busy_o)
    );

    always #(CLK_NS / 2) clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (e_o === 1'b1) begin
            got.push_back(d_o);
            got_t.push_back(cyc);
        end
        if (frame_err_o === 1'b1) ferr_cnt++;
        if (e_o === 1'b1 && frame_err_o === 1'b1) both_cnt++;
    end

    // Far-end transmitter: start, 8 data LSB first, stop; line left at stop.
    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input int bit_ns);
        rx_i = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            #(bit_ns);
        end
        rx_i = stop;
        #(bit_ns);
    endtask

    task automatic clear_obs();
        got.delete();
        got_t.delete();
        ferr_cnt = 0;
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        rx_i   = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_chk++;
        if (e_o !== 1'b0) $display("FAIL reset_e: got %b want 0", e_o);
        else n_pass++;
        n_chk++;
        if (frame_err_o !== 1'b0) $display("FAIL reset_ferr: got %b want 0", frame_err_o);
        else n_pass++;
        n_chk++;
        if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_o);
        else n_pass++;
        n_chk++;
        if (d_o !== 8'h00) $display("FAIL reset_d: got %h want 00", d_o);
        else n_pass++;
        resetn = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_single();
        int t0;
        int lat;
        clear_obs();
        align();
        t0 = cyc;
        send_frame(8'hA5, 1'b1, BIT_NS);
        #(2 * BIT_NS);
        n_chk++;
        if (got.size() != 1) $display("FAIL single_count: got %0d want 1", got.size());
        else n_pass++;
        if (got.size() >= 1) begin
            lat = got_t[0] - t0;
            n_chk++;
            if (got[0] !== 8'hA5) $display("FAIL single_data: got %h want a5", got[0]);
            else n_pass++;
            n_chk++;
            if (lat < 153 || lat > 155)
                $display("FAIL single_latency: got %0d want 154+/-1", lat);
            else n_pass++;
        end
        n_chk++;
        if (ferr_cnt != 0) $display("FAIL single_ferr: got %0d want 0", ferr_cnt);
        else n_pass++;
        n_chk++;
        if (d_o !== 8'hA5) $display("FAIL single_hold: got %h want a5", d_o);
        else n_pass++;
    endtask

    task automatic test_glitch();
        clear_obs();
        align();
        rx_i = 1'b0;
        #(5 * CLK_NS);
        rx_i = 1'b1;
        n_chk++;
        if (busy_o !== 1'b1) $display("FAIL glitch_busy_hi: got %b want 1", busy_o);
        else n_pass++;
        #(2 * BIT_NS);
        n_chk++;
        if (busy_o !== 1'b0) $display("FAIL glitch_busy_lo: got %b want 0", busy_o);
        else n_pass++;
        n_chk++;
        if (got.size() != 0) $display("FAIL glitch_e: got %0d strobes want 0", got.size());
        else n_pass++;
        n_chk++;
        if (ferr_cnt != 0) $display("FAIL glitch_ferr: got %0d want 0", ferr_cnt);
        else n_pass++;
    endtask

    task automatic test_frame_err();
        clear_obs();
        align();
        send_frame(8'h11, 1'b1, BIT_NS);
        send_frame(8'h3C, 1'b0, BIT_NS);
        #(2 * BIT_NS);
        n_chk++;
        if (busy_o !== 1'b1) $display("FAIL ferr_busy_hi: got %b want 1", busy_o);
        else n_pass++;
        n_chk++;
        if (ferr_cnt != 1) $display("FAIL ferr_count: got %0d want 1", ferr_cnt);
        else n_pass++;
        n_chk++;
        if (d_o !== 8'h11) $display("FAIL ferr_hold: got %h want 11", d_o);
        else n_pass++;
        n_chk++;
        if (got.size() != 1) $display("FAIL ferr_strobes: got %0d want 1", got.size());
        else n_pass++;
        rx_i = 1'b1;
        #(BIT_NS);
        n_chk++;
        if (busy_o !== 1'b0) $display("FAIL ferr_busy_lo: got %b want 0", busy_o);
        else n_pass++;
        n_chk++;
        if (ferr_cnt != 1) $display("FAIL ferr_once: got %0d want 1", ferr_cnt);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp[$];
        clear_obs();
        exp = '{8'h00, 8'hFF, 8'h80};
        align();
        foreach (exp[i]) send_frame(exp[i], 1'b1, BIT_NS);
        #(2 * BIT_NS);
        n_chk++;
        if (got.size() != exp.size())
            $display("FAIL b2b_count: got %0d want %0d", got.size(), exp.size());
        else n_pass++;
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            n_chk++;
            if (got[i] !== exp[i]) $display("FAIL b2b_data%0d: got %h want %h", i, got[i], exp[i]);
            else n_pass++;
        end
        n_chk++;
        if (ferr_cnt != 0) $display("FAIL b2b_ferr: got %0d want 0", ferr_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] junk;
        junk = 8'($urandom);
        clear_obs();
        align();
        rx_i = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            rx_i = junk[i];
            #(BIT_NS);
        end
        rx_i = junk[4];
        #(BIT_NS / 2);
        resetn = 1'b0;
        #(3 * CLK_NS);
        n_chk++;
        if ({e_o, frame_err_o, busy_o, d_o} !== 11'h000)
            $display("FAIL rstmid_outputs: got e=%b f=%b b=%b d=%h want all 0",
                     e_o, frame_err_o, busy_o, d_o);
        else n_pass++;
        #(BIT_NS / 2 - 3 * CLK_NS);
        for (int i = 5; i < 8; i++) begin
            rx_i = junk[i];
            #(BIT_NS);
        end
        rx_i = 1'b1;
        #(2 * BIT_NS);
        n_chk++;
        if (busy_o !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy_o);
        else n_pass++;
        resetn = 1'b1;
        #(BIT_NS);
        align();
        send_frame(8'h5A, 1'b1, BIT_NS);
        #(2 * BIT_NS);
        n_chk++;
        if (got.size() != 1) $display("FAIL rstmid_count: got %0d want 1", got.size());
        else n_pass++;
        n_chk++;
        if (got.size() < 1 || got[0] !== 8'h5A)
            $display("FAIL rstmid_data: got %h want 5a", (got.size() > 0) ? got[0] : 8'hxx);
        else n_pass++;
        n_chk++;
        if (ferr_cnt != 0) $display("FAIL rstmid_ferr: got %0d want 0", ferr_cnt);
        else n_pass++;
    endtask

    // Reference: every frame with a high stop bit yields its byte, in order.
    task automatic run_stream(input string name, input logic [7:0] bytes_in[$],
                              input int bit_ns, input int max_gap_ns);
        clear_obs();
        align();
        foreach (bytes_in[i]) begin
            send_frame(bytes_in[i], 1'b1, bit_ns);
            if (max_gap_ns > 0) #($urandom_range(0, max_gap_ns));
        end
        #(3 * BIT_NS);
        n_chk++;
        if (got.size() != bytes_in.size())
            $display("FAIL %s_count: got %0d want %0d", name, got.size(), bytes_in.size());
        else n_pass++;
        for (int i = 0; i < bytes_in.size() && i < got.size(); i++) begin
            n_chk++;
            if (got[i] !== bytes_in[i])
                $display("FAIL %s_data%0d: got %h want %h", name, i, got[i], bytes_in[i]);
            else n_pass++;
        end
        n_chk++;
        if (ferr_cnt != 0) $display("FAIL %s_ferr: got %0d want 0", name, ferr_cnt);
        else n_pass++;
    endtask

    task automatic test_loopback();
        logic [7:0] q[$];
        for (int i = 0; i < 256; i++) q.push_back(8'(i));
        run_stream("all256", q, BIT_NS, 0);
    endtask

    task automatic test_random_gaps();
        logic [7:0] q[$];
        for (int i = 0; i < 24; i++) q.push_back(8'($urandom));
        run_stream("gaps", q, BIT_NS, 300);
    endtask

    task automatic test_drift();
        logic [7:0] q[$];
        for (int i = 0; i < 24; i++) q.push_back(8'($urandom));
        run_stream("fast3pct", q, (BIT_NS * 97) / 100, 0);
        q.delete();
        for (int i = 0; i < 24; i++) q.push_back(8'($urandom));
        run_stream("slow3pct", q, (BIT_NS * 103) / 100, 0);
    endtask

    task automatic test_exclusive();
        n_chk++;
        if (both_cnt != 0) $display("FAIL excl_strobes: got %0d overlaps want 0", both_cnt);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
        test_loopback();
        test_random_gaps();
        test_drift();
        test_exclusive();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
